// File: rtl/rfft_io_ctrl.sv
// Host-side sequencer for a 4-lane FFT core: streams a frame into the core RAM,
// waits for the core with a timeout, then streams results out through a 2-entry FIFO.
// state   | meaning
// IDLE    | host owns RAM, waiting for the first sample
// LOAD    | sample beats written to core addresses 0..DEPTH-1
// COMPUTE | core owns RAM, timeout timer running
// UNLOAD  | results read back in address order
module rfft_io_ctrl #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 64,
   parameter int TIMEOUT = 1023
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               s_valid_i,
   output logic               s_ready_o,
   input  logic [4*WIDTH-1:0] s_data_i,
   output logic               m_valid_o,
   input  logic               m_ready_i,
   output logic [4*WIDTH-1:0] m_data_o,
   output logic               m_last_o,
   output logic               core_input_o,
   output logic               core_write_o,
   output logic [5:0]         core_addr_o,
   output logic [WIDTH-1:0]   core_din0_o,
   output logic [WIDTH-1:0]   core_din1_o,
   output logic [WIDTH-1:0]   core_din2_o,
   output logic [WIDTH-1:0]   core_din3_o,
   input  logic [WIDTH-1:0]   core_dout0_i,
   input  logic [WIDTH-1:0]   core_dout1_i,
   input  logic [WIDTH-1:0]   core_dout2_i,
   input  logic [WIDTH-1:0]   core_dout3_i,
   input  logic               core_done_i,
   output logic               busy_o,
   output logic               err_o
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [6:0] DEPTH_C = 7'(DEPTH);
   localparam logic [6:0] LAST_C  = 7'(DEPTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

   state_t               state_q, state_d;
   logic [6:0]           beat_cnt_q, beat_cnt_d;
   logic                 wr_en_q, wr_en_d;
   logic [5:0]           wr_addr_q, wr_addr_d;
   logic [4*WIDTH-1:0]   din_q, din_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 err_q, err_d;
   logic [6:0]           rd_cnt_q, rd_cnt_d;
   logic                 infl_q, infl_d;
   logic                 infl_last_q, infl_last_d;
   logic [4*WIDTH-1:0]   fifo_data_q [2];
   logic [4*WIDTH-1:0]   fifo_data_d [2];
   logic [1:0]           fifo_last_q, fifo_last_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic [1:0]           fcnt_q, fcnt_d;

   logic                 accept, pop, issue;
   logic [2:0]           occ;

   assign s_ready_o = (state_q == ST_LOAD) && (beat_cnt_q < DEPTH_C);
   assign accept    = s_valid_i && s_ready_o;
   assign m_valid_o = (fcnt_q != 2'd0);
   assign pop       = m_valid_o && m_ready_i;
   // Occupancy after this cycle's pop, so a steady stream keeps one read in flight.
   assign occ       = {1'b0, fcnt_q} + {2'b00, infl_q} - {2'b00, pop};
   assign issue     = (state_q == ST_UNLOAD) && (rd_cnt_q < DEPTH_C) && (occ < 3'd2);

   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      wr_en_d     = accept;
      wr_addr_d   = wr_addr_q;
      din_d       = din_q;
      timer_d     = timer_q;
      err_d       = err_q;
      rd_cnt_d    = rd_cnt_q;
      infl_d      = issue;
      infl_last_d = issue && (rd_cnt_q == LAST_C);
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fcnt_d      = fcnt_q + {1'b0, infl_q} - {1'b0, pop};

      if (accept) begin
         wr_addr_d  = beat_cnt_q[5:0];
         din_d      = s_data_i;
         beat_cnt_d = beat_cnt_q + 7'd1;
      end
      if (issue) rd_cnt_d = rd_cnt_q + 7'd1;
      if (infl_q) begin
         fifo_data_d[wr_ptr_q] = {core_dout3_i, core_dout2_i, core_dout1_i, core_dout0_i};
         fifo_last_d[wr_ptr_q] = infl_last_q;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;

      case (state_q)
         ST_IDLE: begin
            if (s_valid_i) begin
               state_d    = ST_LOAD;
               beat_cnt_d = '0;
               err_d      = 1'b0;
            end
         end
         ST_LOAD: begin
            if (wr_en_q && (beat_cnt_q == DEPTH_C)) begin
               state_d = ST_COMPUTE;
               timer_d = TW'(TIMEOUT - 1);
            end
         end
         ST_COMPUTE: begin
            if (core_done_i) begin
               state_d  = ST_UNLOAD;
               rd_cnt_d = '0;
            end else if (timer_q == '0) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         ST_UNLOAD: begin
            if (pop && fifo_last_q[rd_ptr_q]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         beat_cnt_q  <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         din_q       <= '0;
         timer_q     <= '0;
         err_q       <= 1'b0;
         rd_cnt_q    <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         fifo_data_q <= '{default: '0};
         fifo_last_q <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         fcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         din_q       <= din_d;
         timer_q     <= timer_d;
         err_q       <= err_d;
         rd_cnt_q    <= rd_cnt_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         fifo_data_q <= fifo_data_d;
         fifo_last_q <= fifo_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fcnt_q      <= fcnt_d;
      end
   end

   assign m_data_o     = fifo_data_q[rd_ptr_q];
   assign m_last_o     = m_valid_o && fifo_last_q[rd_ptr_q];
   assign core_input_o = (state_q != ST_COMPUTE);
   assign core_write_o = wr_en_q;
   assign core_addr_o  = (state_q == ST_UNLOAD) ? rd_cnt_q[5:0] : wr_addr_q;
   assign core_din0_o  = din_q[0*WIDTH +: WIDTH];
   assign core_din1_o  = din_q[1*WIDTH +: WIDTH];
   assign core_din2_o  = din_q[2*WIDTH +: WIDTH];
   assign core_din3_o  = din_q[3*WIDTH +: WIDTH];
   assign busy_o       = (state_q != ST_IDLE);
   assign err_o        = err_q;
endmodule

// File: tb/tb_rfft_io_ctrl.sv
// Bench for rfft_io_ctrl: a core RAM model, a frame-level scoreboard checked every
// cycle, and directed frames covering throughput, back-pressure, timeout and reset.
module tb_rfft_io_ctrl;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         s_valid, s_ready, m_valid, m_ready, m_last;
   logic [127:0] s_data, m_data;
   logic         core_input, core_write, core_done, busy, err;
   logic [5:0]   core_addr;
   logic [31:0]  din0, din1, din2, din3;
   logic [127:0] dout_q;
   logic [127:0] ram [64];

   int           n_cmp = 0, n_bad = 0, cyc = 0;
   logic [127:0] exp_q[$];
   logic [127:0] sent [64];
   int           rx_n = 0, first_valid_cyc = -1, last_pop_cyc = -1;
   logic [127:0] first_data, last_data, prev_data, pw_data;
   logic         pw = 1'b0, prev_stall = 1'b0;
   int           pw_addr = 0, model_n = 0, wr_run = 0, last_run = 0;

   rfft_io_ctrl dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
      .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
      .core_input_o(core_input), .core_write_o(core_write), .core_addr_o(core_addr),
      .core_din0_o(din0), .core_din1_o(din1), .core_din2_o(din2), .core_din3_o(din3),
      .core_dout0_i(dout_q[31:0]), .core_dout1_i(dout_q[63:32]),
      .core_dout2_i(dout_q[95:64]), .core_dout3_i(dout_q[127:96]),
      .core_done_i(core_done), .busy_o(busy), .err_o(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Core stand-in: result is the stored frame with lanes reversed and a tag mixed in.
   function automatic logic [127:0] xf(input logic [127:0] x);
      logic [31:0] c;
      c = 32'h5A5A_0000;
      return {x[31:0] ^ c, x[63:32] ^ c, x[95:64] ^ c, x[127:96] ^ c};
   endfunction

   always @(posedge clk) begin
      if (core_write) ram[core_addr] <= {din3, din2, din1, din0};
      dout_q <= xf(ram[core_addr]);
   end

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   function automatic logic [127:0] beat(input int tag, input int n);
      logic [127:0] v;
      for (int k = 0; k < 4; k++) v[k*32 +: 32] = {8'(tag), 16'(n), 8'(k)};
      return v;
   endfunction

   function automatic logic pat_ready(input int mode, input int k);
      if (mode == 0) return 1'b1;
      return (k % 4 == 0) || (k % 4 == 3);
   endfunction

   // Per-cycle scoreboard: accepted beat n -> write to address n next cycle;
   // result beats leave in address order with last only on the final one.
   always @(negedge clk) begin
      if (!rst_n) begin
         pw = 1'b0; model_n = 0; prev_stall = 1'b0; wr_run = 0; rx_n = 0;
         exp_q.delete();
      end else begin
         chk("core_write", core_write, pw);
         if (pw) begin
            chk("core_addr", core_addr, pw_addr);
            chk("core_din", {din3, din2, din1, din0}, pw_data);
         end
         if (core_write) wr_run++;
         else begin
            if (wr_run != 0) last_run = wr_run;
            wr_run = 0;
         end
         pw = s_valid && s_ready;
         if (pw) begin
            pw_addr = model_n; pw_data = s_data; model_n = (model_n + 1) % 64;
         end
         if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
         end
         if (m_valid) begin
            if (exp_q.size() == 0) chk("m_valid_unexpected", m_valid, 0);
            else begin
               chk("m_data", m_data, exp_q[0]);
               chk("m_last", m_last, rx_n == 63);
               if (rx_n == 0 && first_valid_cyc < 0) begin
                  first_valid_cyc = cyc; first_data = m_data;
               end
               if (m_ready) begin
                  if (rx_n == 63) last_data = m_data;
                  void'(exp_q.pop_front());
                  rx_n++;
                  last_pop_cyc = cyc;
               end
            end
         end else if (m_last) chk("m_last_without_valid", m_last, 0);
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   task automatic check_reset(input string p);
      chk({p, "_s_ready"}, s_ready, 0);
      chk({p, "_m_valid"}, m_valid, 0);
      chk({p, "_m_last"}, m_last, 0);
      chk({p, "_m_data"}, m_data, 0);
      chk({p, "_core_input"}, core_input, 1);
      chk({p, "_core_write"}, core_write, 0);
      chk({p, "_core_addr"}, core_addr, 0);
      chk({p, "_core_din"}, {din3, din2, din1, din0}, 0);
      chk({p, "_busy"}, busy, 0);
      chk({p, "_err"}, err, 0);
   endtask

   // Returns #1 after the edge that accepted the last beat (the address-63 write cycle).
   task automatic send_frame(input int tag, input bit gaps);
      int  n, guard;
      bit  acc;
      n = 0; guard = 0;
      @(posedge clk); #1;
      while (n < 64 && guard < 400) begin
         s_valid = !(gaps && (guard % 3 == 2));
         s_data  = beat(tag, n);
         @(negedge clk);
         acc = s_valid && s_ready;
         @(posedge clk); #1;
         if (acc) begin sent[n] = s_data; n++; end
         guard++;
      end
      s_valid = 1'b0;
      if (n < 64) chk("send_timeout", n, 64);
   endtask

   // Entered at the negedge of the first COMPUTE cycle.
   task automatic finish_frame(input int mode, input int stop, output int u);
      int k;
      repeat (500) @(posedge clk);
      #1;
      core_done = 1'b1;
      rx_n = 0; first_valid_cyc = -1;
      for (int i = 0; i < 64; i++) exp_q.push_back(xf(sent[i]));
      m_ready = pat_ready(mode, 0);
      @(negedge clk); chk("core_input_before_unload", core_input, 0);
      @(negedge clk); chk("core_input_rise", core_input, 1);
      u = cyc;
      @(posedge clk); #1;
      core_done = 1'b0;
      k = 1;
      while (rx_n < 64 && !(stop >= 0 && rx_n >= stop) && k < 600) begin
         m_ready = pat_ready(mode, k);
         @(posedge clk); #1;
         k++;
      end
      if (k >= 600) chk("unload_timeout", rx_n, 64);
   endtask

   initial begin
      int u, cnt;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; core_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); check_reset("reset");

      // Frame 1: back-to-back load, free-flowing unload
      send_frame(1, 1'b0);
      @(negedge clk);
      chk("w63_write", core_write, 1);
      chk("w63_addr", core_addr, 63);
      chk("w63_din", {din3, din2, din1, din0}, 128'h01003F03_01003F02_01003F01_01003F00);
      chk("w63_core_input", core_input, 1);
      @(negedge clk); chk("core_input_fall", core_input, 0);
      finish_frame(0, -1, u);
      chk("write_run_len", last_run, 64);
      @(negedge clk);
      chk("f1_busy_after", busy, 0);
      chk("f1_beats", rx_n, 64);
      chk("f1_first_latency", first_valid_cyc - u, 2);
      chk("f1_last_pop", last_pop_cyc - u, 65);
      chk("f1_first_data", first_data, 128'h5B5A0000_5B5A0001_5B5A0002_5B5A0003);
      chk("f1_last_data", last_data, 128'h5B5A3F00_5B5A3F01_5B5A3F02_5B5A3F03);

      // Frame 2: gapped load, 1,0,0,1 back-pressure
      send_frame(2, 1'b1);
      @(negedge clk);
      @(negedge clk); chk("f2_core_input_fall", core_input, 0);
      finish_frame(1, -1, u);
      @(negedge clk);
      chk("f2_busy_after", busy, 0);
      chk("f2_beats", rx_n, 64);

      // Frame 3: core never finishes
      m_ready = 1'b1;
      send_frame(3, 1'b0);
      @(negedge clk);
      @(negedge clk); chk("f3_core_input_fall", core_input, 0);
      cnt = 1;
      while (cnt < 1100) begin
         @(negedge clk);
         if (core_input) break;
         cnt++;
      end
      chk("timeout_len", cnt, 1023);
      chk("timeout_err", err, 1);
      chk("timeout_busy", busy, 0);

      // Frame 4: err clears on start, reset after 20 result beats
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = beat(4, 0);
      @(negedge clk); chk("err_held_idle", err, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
      chk("err_cleared", err, 0);
      chk("load_busy", busy, 1);
      send_frame(4, 1'b0);
      @(negedge clk);
      @(negedge clk); chk("f4_core_input_fall", core_input, 0);
      finish_frame(0, 20, u);
      chk("f4_beats_before_reset", rx_n, 20);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_ready = 1'b1;
      @(negedge clk); check_reset("midreset");

      // Frame 5: normal frame after abort
      send_frame(5, 1'b0);
      @(negedge clk);
      @(negedge clk); chk("f5_core_input_fall", core_input, 0);
      finish_frame(0, -1, u);
      @(negedge clk);
      chk("f5_busy_after", busy, 0);
      chk("f5_beats", rx_n, 64);
      chk("f5_first_latency", first_valid_cyc - u, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/rfft_io_ctrl.md
RFFT_IO_CTRL -- requirements
Module: rfft_io_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, bits per sample word (one of four lanes).
REQ-002 Parameter: DEPTH, 64, core addresses per frame (6-bit address).
REQ-003 Parameter: TIMEOUT, 1023, maximum COMPUTE cycles before abort.
REQ-004 Clk  in  1  sole clock; all logic SHALL act on its rising edge.
REQ-005 Reset_n  in  1  reset, synchronous and active-low.
REQ-006 S_valid / S_ready  in / out  1 / 1  sample stream handshake.
REQ-007 S_data  in  4*WIDTH  lane k (bits k*WIDTH+:WIDTH) SHALL drive core Din k.
REQ-008 M_valid / M_ready  out / in  1 / 1  result stream handshake.
REQ-009 M_data  out  4*WIDTH  lane k SHALL carry core Dout k.
REQ-010 M_last  out  1  high on the beat for address DEPTH-1.
REQ-011 Core_input  out  1  drives core Input; 1 = host owns the RAM port.
REQ-012 Core_write  out  1  drives core Write.
REQ-013 Core_addr  out  6  drives core Addr.
REQ-014 Core_din0..3  out  WIDTH each  drive core Din0..3.
REQ-015 Core_dout0..3  in  WIDTH each  core Dout0..3; valid 1 cycle after Core_addr is presented.
REQ-016 Core_done  in  1  core completion flag.
REQ-017 Busy  out  1  high in any state except IDLE.
REQ-018 Err  out  1  sticky timeout flag.

Function
REQ-019 States SHALL be IDLE, LOAD, COMPUTE, UNLOAD; IDLE->LOAD SHALL occur on the first cycle with S_valid=1 in IDLE.
REQ-020 S_ready SHALL be 1 only in LOAD while the beat counter < DEPTH.
REQ-021 Entering LOAD SHALL clear Err and the beat counter.
REQ-022 Each accepted S beat n SHALL produce, in the next cycle, Core_write=1, Core_addr=n, Core_din=lanes of that beat, and Core_input=1.
REQ-023 Core_write SHALL be 0 in every cycle that follows no accepted S beat, and in all states except LOAD.
REQ-024 Core_input SHALL be 1 in IDLE, LOAD, and UNLOAD, and 0 only in COMPUTE.
REQ-025 The state SHALL change from LOAD to COMPUTE in the cycle after the write for address DEPTH-1, so Core_input falls exactly one cycle after that write.
REQ-026 COMPUTE SHALL count cycles. On Core_done=1 the state SHALL change to UNLOAD in the next cycle.
REQ-027 If the COMPUTE count reaches TIMEOUT without Core_done, the block SHALL set Err=1 and enter IDLE with no M beats.
REQ-028 UNLOAD SHALL issue Core_addr 0..DEPTH-1 in order with Core_write=0.
REQ-029 Read data SHALL be captured one cycle after the address is issued, into a 2-entry output FIFO.
REQ-030 An address SHALL be issued only if FIFO occupancy plus in-flight reads is less than 2. No data SHALL be lost or duplicated under any M_ready pattern.
REQ-031 M_valid SHALL equal "FIFO not empty". M_data and M_last SHALL come from the FIFO head.
REQ-032 M_data SHALL hold stable while M_valid=1 and M_ready=0.
REQ-033 With M_ready held at 1, UNLOAD SHALL sustain 1 beat per cycle after a 2-cycle initial latency.
REQ-034 When the M_last beat is accepted, the state SHALL change to IDLE in the next cycle.
REQ-035 S_valid SHALL be ignored outside IDLE and LOAD. Counters SHALL be 7 bits wide so that the DEPTH boundary is detected without wrap-around.

Reset
REQ-036 While Reset_n=0 at a clock edge, the next state SHALL be IDLE with the FIFO emptied and all counters cleared.
REQ-037 Output values after that edge SHALL be: S_ready=0, M_valid=0, M_last=0, M_data=0, Core_input=1, Core_write=0, Core_addr=0, Core_din0..3=0, Busy=0, Err=0.
REQ-038 A reset in any state, including mid-LOAD and mid-UNLOAD, SHALL abort the frame with no further M beats. A new frame SHALL then proceed normally.

Verification
REQ-039 Hold Reset_n=0 for 2 cycles -> every output at its REQ-037 value; Core_input=1.
REQ-040 Send 64 back-to-back S beats with lane k = {beat,k} -> Core_write high for 64 consecutive cycles, Core_addr 0..63, Core_din matching; Core_input=0 in the cycle after address 63.
REQ-041 Core model raises Core_done 500 cycles after Core_input falls, with M_ready=1 -> Core_input=1 one cycle later; 64 M beats with M_data = model RAM[0..63] in order; M_last only on beat 63; then Busy=0.
REQ-042 During UNLOAD, M_ready follows the pattern 1,0,0,1 repeating -> exactly 64 beats, correct order, stable data while stalled.
REQ-043 Core_done never asserted -> Err=1 and IDLE after 1023 COMPUTE cycles with no M_valid; Err clears on the next frame's first S beat.
REQ-044 Reset_n pulsed low after 20 UNLOAD beats -> REQ-037 values on the next cycle; a following full frame completes correctly.
